// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/write-back,
// stalls on mem_ready, counts retired instructions and flags unsupported opcodes.
module mc_control #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             BranchNe,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StRwb    = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StAddiEx = 4'd10;
  localparam logic [3:0] StAddiWb = 4'd11;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             ready;
  logic             op_illegal;
  logic             retire;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_d    = StFetch;
    op_illegal = 1'b0;
    retire     = 1'b0;
    case (state_q)
      StFetch:  state_d = ready ? StDecode : StFetch;
      StDecode: begin
        case (OpCode)
          OpRType:      state_d = StExec;
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi:       state_d = StAddiEx;
          default:      op_illegal = 1'b1;
        endcase
      end
      StMemAdr: state_d = (OpCode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = ready ? StMemWb : StMemRd;
      StMemWr: begin
        state_d = ready ? StFetch : StMemWr;
        retire  = ready;
      end
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRwb, StBranch, StJump, StAddiWb: retire = 1'b1;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= op_illegal;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs decode state only, except the FETCH handshake; all held low during reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    BranchNe    = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = ready;
          PCWrite = ready;
        end
        StDecode: ALUSrcB = 2'b11;
        StMemAdr, StAddiEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        StRwb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNe    = OpCode[0];
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        StAddiWb: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: reset, instruction traces, memory stalls, branches,
// illegal opcodes and counter wrap (second instance with CNT_W=4, no memory wait).
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic RegWrite, RegDst, ALUSrcA, BranchNe, illegal;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;
  logic [31:0] retired;

  logic pcw4, pwc4, iord4, mr4, mw4, mtr4, irw4, rw4, rd4, sa4, bne4, illegal4;
  logic [1:0] aop4, sb4, ps4;
  logic [3:0] state4;
  logic [3:0] retired4;

  logic [16:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
                 RegDst, ALUSrcA, BranchNe, ALUOp, ALUSrcB, PCSource};

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .BranchNe(BranchNe), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .illegal(illegal), .state(state),
    .retired(retired)
  );

  mc_control #(.MEM_WAIT_EN(1'b0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(pcw4), .PCWriteCond(pwc4), .IorD(iord4), .MemRead(mr4),
    .MemWrite(mw4), .MemtoReg(mtr4), .IRWrite(irw4), .RegWrite(rw4),
    .RegDst(rd4), .ALUSrcA(sa4), .BranchNe(bne4), .ALUOp(aop4),
    .ALUSrcB(sb4), .PCSource(ps4), .illegal(illegal4), .state(state4),
    .retired(retired4)
  );

  // Expected control word per state, straight from the state/output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic op0);
    logic pcw, pwc, iord, mr, mw, mtr, irw, rw, rd, sa, bne;
    logic [1:0] aop, sb, ps;
    {pcw, pwc, iord, mr, mw, mtr, irw, rw, rd, sa, bne} = '0;
    aop = 2'b00;
    sb  = 2'b00;
    ps  = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; mtr = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; bne = op0; end
      4'd9:  begin pcw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pwc, iord, mr, mw, mtr, irw, rw, rd, sa, bne, aop, sb, ps};
  endfunction

  logic [5:0] seq_ops  [6]  = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
  int         seq_lens [6]  = '{4, 5, 4, 3, 3, 4};
  logic [3:0] seq_trace[23] = '{4'd0, 4'd1, 4'd6, 4'd7,
                                4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                4'd0, 4'd1, 4'd2, 4'd5,
                                4'd0, 4'd1, 4'd8,
                                4'd0, 4'd1, 4'd9,
                                4'd0, 4'd1, 4'd10, 4'd11};
  logic       wait_rdy [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
  logic [3:0] wait_st  [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};

  // Leaves the bench at a falling edge with both DUTs in FETCH, first cycle after release.
  task automatic do_reset();
    mem_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++;
    if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_cmp++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctrl !== 17'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ctrl !== exp_ctrl(4'd0, 1'b1, 1'b0))
      begin n_fail++; $display("FAIL reset_release_ctrl: got %h want %h", ctrl, exp_ctrl(4'd0, 1'b1, 1'b0)); end
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int idx = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      OpCode = seq_ops[k];
      for (int i = 0; i < seq_lens[k]; i++) begin
        #1;
        n_cmp++;
        if (state !== seq_trace[idx])
          begin n_fail++; $display("FAIL seq_state[%0d]: got %0d want %0d", idx, state, seq_trace[idx]); end
        n_cmp++;
        if (ctrl !== exp_ctrl(seq_trace[idx], 1'b1, OpCode[0]))
          begin n_fail++; $display("FAIL seq_ctrl[%0d]: got %h want %h", idx, ctrl, exp_ctrl(seq_trace[idx], 1'b1, OpCode[0])); end
        idx++;
        @(negedge clk);
      end
    end
    #1;
    n_cmp++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL seq_end_state: got %0d want 0", state); end
    n_cmp++;
    if (retired !== 32'd6) begin n_fail++; $display("FAIL seq_retired: got %0d want 6", retired); end
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    do_reset();
    OpCode = 6'h23;
    for (int c = 0; c < 10; c++) begin
      mem_ready = wait_rdy[c];
      #1;
      n_cmp++;
      if (state !== wait_st[c])
        begin n_fail++; $display("FAIL wait_state[%0d]: got %0d want %0d", c, state, wait_st[c]); end
      n_cmp++;
      if (IRWrite !== (c == 3))
        begin n_fail++; $display("FAIL wait_irwrite[%0d]: got %b want %b", c, IRWrite, c == 3); end
      n_cmp++;
      if (ctrl !== exp_ctrl(wait_st[c], wait_rdy[c], 1'b1))
        begin n_fail++; $display("FAIL wait_ctrl[%0d]: got %h want %h", c, ctrl, exp_ctrl(wait_st[c], wait_rdy[c], 1'b1)); end
      if (c == 1) begin
        n_cmp++;
        if (state4 !== 4'd1)
          begin n_fail++; $display("FAIL nowait_state: got %0d want 1", state4); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL wait_end_state: got %0d want 0", state); end
    n_cmp++;
    if (retired !== 32'd1) begin n_fail++; $display("FAIL wait_retired: got %0d want 1", retired); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    do_reset();
    OpCode = 6'b000101;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd8) begin n_fail++; $display("FAIL bne_state: got %0d want 8", state); end
    n_cmp++;
    if ({BranchNe, PCWriteCond, PCSource} !== 4'b1101)
      begin n_fail++; $display("FAIL bne_ctrl: got %b want 1101", {BranchNe, PCWriteCond, PCSource}); end
    @(negedge clk);
    OpCode = 6'b000100;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd8) begin n_fail++; $display("FAIL beq_state: got %0d want 8", state); end
    n_cmp++;
    if ({BranchNe, PCWriteCond, PCSource} !== 4'b0101)
      begin n_fail++; $display("FAIL beq_ctrl: got %b want 0101", {BranchNe, PCWriteCond, PCSource}); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (retired !== 32'd2) begin n_fail++; $display("FAIL branch_retired: got %0d want 2", retired); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_reset();
    OpCode = 6'b111111;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({state, illegal} !== {4'd1, 1'b0})
      begin n_fail++; $display("FAIL illegal_decode: got %0d/%b want 1/0", state, illegal); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({state, illegal} !== {4'd0, 1'b1})
      begin n_fail++; $display("FAIL illegal_pulse: got %0d/%b want 0/1", state, illegal); end
    n_cmp++;
    if (retired !== 32'd0) begin n_fail++; $display("FAIL illegal_retired: got %0d want 0", retired); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({state, illegal} !== {4'd1, 1'b0})
      begin n_fail++; $display("FAIL illegal_clear: got %0d/%b want 1/0", state, illegal); end
    n_cmp++;
    if (retired !== 32'd0) begin n_fail++; $display("FAIL illegal_retired2: got %0d want 0", retired); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    OpCode = 6'b000010;
    repeat (51) @(negedge clk);
    #1;
    n_cmp++;
    if (retired4 !== 4'd1) begin n_fail++; $display("FAIL wrap_retired4: got %0d want 1", retired4); end
    n_cmp++;
    if (retired !== 32'd17) begin n_fail++; $display("FAIL wrap_retired32: got %0d want 17", retired); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    OpCode = 6'b000010;
    repeat (3) @(negedge clk);
    OpCode = 6'h23;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({state, MemRead, retired} !== {4'd3, 1'b1, 32'd1})
      begin n_fail++; $display("FAIL midrd_pre: got %0d/%b/%0d want 3/1/1", state, MemRead, retired); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({state, retired, illegal} !== {4'd0, 32'd0, 1'b0})
      begin n_fail++; $display("FAIL midrd_reset: got %0d/%0d/%b want 0/0/0", state, retired, illegal); end
    n_cmp++;
    if (ctrl !== 17'd0) begin n_fail++; $display("FAIL midrd_ctrl: got %h want 0", ctrl); end
    @(negedge clk);
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({MemRead, ALUSrcB, state} !== {1'b1, 2'b01, 4'd0})
      begin n_fail++; $display("FAIL midrd_release: got %b/%b/%0d want 1/01/0", MemRead, ALUSrcB, state); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_wrap();
    test_reset_mid_memrd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
